// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing source with sync/DE/pixel re-alignment (optional VTG_TEST_PATTERN_EN adds test_mode colour bars)
module video_timing_gen #(
    parameter int   H_ACTIVE    = 1280,
    parameter int   H_FP        = 110,
    parameter int   H_SYNC      = 40,
    parameter int   H_BP        = 220,
    parameter int   V_ACTIVE    = 720,
    parameter int   V_FP        = 5,
    parameter int   V_SYNC      = 5,
    parameter int   V_BP        = 20,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   PIX_LATENCY = 2
) (
    input  logic               pixel_clk,
    input  logic               rst,
`ifdef VTG_TEST_PATTERN_EN
    input  logic               test_mode,
`endif
    input  logic [0:2][7:0]    pixel_in,
    output logic signed [11:0] hpos,
    output logic signed [11:0] vpos,
    output logic               active,
    output logic               fsync,
    output logic               de_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [0:2][7:0]    pixel_out,
    output logic [15:0]        frame_cnt
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;

    localparam logic signed [11:0] H_START  = 12'(-H_BLANK);
    localparam logic signed [11:0] H_LAST   = 12'(H_ACTIVE - 1);
    localparam logic signed [11:0] HS_FIRST = 12'(-(H_SYNC + H_BP));
    localparam logic signed [11:0] HS_LAST  = 12'(-H_BP - 1);
    localparam logic signed [11:0] V_START  = 12'(-V_BLANK);
    localparam logic signed [11:0] V_LAST   = 12'(V_ACTIVE - 1);
    localparam logic signed [11:0] VS_FIRST = 12'(-(V_SYNC + V_BP));
    localparam logic signed [11:0] VS_LAST  = 12'(-V_BP - 1);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    // Delay-line stage whose contents move into the aligned outputs on the next edge.
    localparam int SRC = (PIX_LATENCY == 0) ? 0 : PIX_LATENCY - 1;

    if (H_BLANK + H_ACTIVE > 2047) begin : g_h_range_err
        $error("video_timing_gen: horizontal total exceeds 2047");
    end
    if (V_BLANK + V_ACTIVE > 2047) begin : g_v_range_err
        $error("video_timing_gen: vertical total exceeds 2047");
    end
    if (PIX_LATENCY < 0 || PIX_LATENCY > 8) begin : g_lat_range_err
        $error("video_timing_gen: PIX_LATENCY outside 0..8");
    end

    // run is low only on the first cycle after reset, holding the raster at frame start.
    logic               run;
    logic signed [11:0] h_nxt;
    logic signed [11:0] v_nxt;
    logic               de_nxt;
    logic               hs_nxt;
    logic               vs_nxt;

    // {de, hsync level, vsync level} per pipeline stage; stage 0 is the current raster position.
    logic [2:0]         ctl_d [0:PIX_LATENCY];
    logic [0:2][7:0]    pix_src;

`ifdef VTG_TEST_PATTERN_EN
    logic [11:0]        hpos_d [0:SRC];
    logic [15:0]        bar_num;
    logic [2:0]         bar_idx;
    logic [2:0]         bar_rgb;
    logic [0:2][7:0]    bar_pix;
`endif

    // Next raster position and the sync/DE flags that belong to it.
    always_comb begin
        h_nxt = hpos + 12'sd1;
        v_nxt = vpos;
        if (!run) begin
            h_nxt = H_START;
            v_nxt = V_START;
        end else if (hpos == H_LAST) begin
            h_nxt = H_START;
            v_nxt = (vpos == V_LAST) ? V_START : vpos + 12'sd1;
        end
        de_nxt = !h_nxt[11] && !v_nxt[11];
        hs_nxt = (h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST);
        vs_nxt = (v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST);
    end

    // Raster counters and frame-start pulse.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hpos  <= H_START;
            vpos  <= V_START;
            run   <= 1'b0;
            fsync <= 1'b0;
        end else begin
            hpos  <= h_nxt;
            vpos  <= v_nxt;
            run   <= 1'b1;
            fsync <= (h_nxt == H_START) && (v_nxt == V_START);
        end
    end

    // Completed-frame counter, stepping the cycle after each fsync.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (fsync) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // DE/sync shift register; sync levels are stored with polarity already applied.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            for (int k = 0; k <= PIX_LATENCY; k++) begin
                ctl_d[k] <= {1'b0, SYNC_IDLE, SYNC_IDLE};
            end
`ifdef VTG_TEST_PATTERN_EN
            for (int k = 0; k <= SRC; k++) begin
                hpos_d[k] <= 12'd0;
            end
`endif
        end else begin
            ctl_d[0] <= {de_nxt,
                         hs_nxt ? SYNC_POL : SYNC_IDLE,
                         vs_nxt ? SYNC_POL : SYNC_IDLE};
            for (int k = 1; k <= PIX_LATENCY; k++) begin
                ctl_d[k] <= ctl_d[k-1];
            end
`ifdef VTG_TEST_PATTERN_EN
            hpos_d[0] <= h_nxt;
            for (int k = 1; k <= SRC; k++) begin
                hpos_d[k] <= hpos_d[k-1];
            end
`endif
        end
    end

    assign active    = ctl_d[0][2];
    assign de_out    = ctl_d[PIX_LATENCY][2];
    assign hsync_out = ctl_d[PIX_LATENCY][1];
    assign vsync_out = ctl_d[PIX_LATENCY][0];

    // Extra pixel stages so that the output register lands on the same cycle as de_out.
    if (PIX_LATENCY >= 2) begin : g_pix_dly
        logic [0:2][7:0] pix_d [1:PIX_LATENCY-1];

        // Pixel shift register ahead of the output register.
        always_ff @(posedge pixel_clk) begin
            if (rst) begin
                for (int k = 1; k <= PIX_LATENCY - 1; k++) begin
                    pix_d[k] <= '0;
                end
            end else begin
                pix_d[1] <= pixel_in;
                for (int k = 2; k <= PIX_LATENCY - 1; k++) begin
                    pix_d[k] <= pix_d[k-1];
                end
            end
        end
        assign pix_src = pix_d[PIX_LATENCY-1];
    end else begin : g_pix_direct
        assign pix_src = pixel_in;
    end

`ifdef VTG_TEST_PATTERN_EN
    // Eight vertical bars across the active width; colour bits are {r, g, b}.
    always_comb begin
        bar_num = {4'd0, hpos_d[SRC]} << 3;
        bar_idx = 3'(bar_num / 16'(H_ACTIVE));
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
        bar_pix = {{8{bar_rgb[0]}}, {8{bar_rgb[1]}}, {8{bar_rgb[2]}}};
    end
`endif

    // Output pixel register; blanking forces black.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            pixel_out <= '0;
        end else if (!ctl_d[SRC][2]) begin
            pixel_out <= '0;
`ifdef VTG_TEST_PATTERN_EN
        end else if (test_mode) begin
            pixel_out <= bar_pix;
`endif
        end else begin
            pixel_out <= pix_src;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a small raster
module tb_video_timing_gen;

    localparam int HA = 8;
    localparam int HF = 1;
    localparam int HS = 2;
    localparam int HB = 1;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int PL = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [0:2][7:0]    pixel_in;
    logic signed [11:0] hpos, vpos, hpos2, vpos2;
    logic               active, fsync, de_out, hsync_out, vsync_out;
    logic               active2, fsync2, de_out2, hsync_out2, vsync_out2;
    logic [0:2][7:0]    pixel_out, pixel_out2;
    logic [15:0]        frame_cnt, frame_cnt2;
`ifdef VTG_TEST_PATTERN_EN
    logic               test_mode = 1'b0;
`endif

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .PIX_LATENCY(PL)
    ) u_dut (
        .pixel_clk(clk),
        .rst(rst),
`ifdef VTG_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pixel_in(pixel_in),
        .hpos(hpos),
        .vpos(vpos),
        .active(active),
        .fsync(fsync),
        .de_out(de_out),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .pixel_out(pixel_out),
        .frame_cnt(frame_cnt)
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIX_LATENCY(0)
    ) u_dut_neg (
        .pixel_clk(clk),
        .rst(rst),
`ifdef VTG_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .pixel_in(pixel_in),
        .hpos(hpos2),
        .vpos(vpos2),
        .active(active2),
        .fsync(fsync2),
        .de_out(de_out2),
        .hsync_out(hsync_out2),
        .vsync_out(vsync_out2),
        .pixel_out(pixel_out2),
        .frame_cnt(frame_cnt2)
    );

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
    } sb_t;

    sb_t sbq[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_hpos",     {20'd0, hpos},      {20'd0, 12'hFFC});
        check("rst_vpos",     {20'd0, vpos},      {20'd0, 12'hFFD});
        check("rst_active",   32'(active),        32'd0);
        check("rst_fsync",    32'(fsync),         32'd0);
        check("rst_de",       32'(de_out),        32'd0);
        check("rst_hsync",    32'(hsync_out),     32'd0);
        check("rst_vsync",    32'(vsync_out),     32'd0);
        check("rst_pixel",    {8'd0, pixel_out},  32'd0);
        check("rst_fcnt",     {16'd0, frame_cnt}, 32'd0);
        check("rst_hsync_n",  32'(hsync_out2),    32'd1);
        check("rst_vsync_n",  32'(vsync_out2),    32'd1);
        check("rst_de_n",     32'(de_out2),       32'd0);
    endtask

    // Runs ncyc cycles from frame start, comparing against a raster model.
    task automatic run(input int ncyc);
        int          fpos, h, v, act_cnt;
        logic        e_act, e_hs, e_vs;
        logic [23:0] pv;
        sb_t         e;
        act_cnt = 0;
        sbq.delete();
        repeat (PL) sbq.push_back('0);
        for (int n = 0; n < ncyc; n++) begin
            fpos  = n % FT;
            h     = -(HF + HS + HB) + (fpos % HT);
            v     = -(VF + VS + VB) + (fpos / HT);
            e_act = (h >= 0) && (v >= 0);
            e_hs  = (h >= -(HS + HB)) && (h <= -HB - 1);
            e_vs  = (v >= -(VS + VB)) && (v <= -VB - 1);
            @(negedge clk);
            check("hpos",   {20'd0, hpos},      {20'd0, 12'(h)});
            check("vpos",   {20'd0, vpos},      {20'd0, 12'(v)});
            check("active", 32'(active),        32'(e_act));
            check("fsync",  32'(fsync),         32'(fpos == 0));
            check("fcnt",   {16'd0, frame_cnt}, 32'((n + FT - 1) / FT));
            e = sbq.pop_front();
            check("de_out",    32'(de_out),       32'(e.de));
            check("hsync_out", 32'(hsync_out),    32'(e.hs));
            check("vsync_out", 32'(vsync_out),    32'(e.vs));
            check("pixel_out", {8'd0, pixel_out}, {8'd0, e.pix});
            check("hsync_neg", 32'(hsync_out2),   32'(!e_hs));
            check("vsync_neg", 32'(vsync_out2),   32'(!e_vs));
            check("de_l0",     32'(de_out2),      32'(e_act));
            if (n < FT && active) act_cnt++;
            if (n == FT - 1) check("active_count", 32'(act_cnt), 32'(HA * VA));
            pv = {8'(h), 8'(v), 8'hA5};
            pixel_in = pv;
            sbq.push_back({e_act, e_hs, e_vs, e_act ? pv : 24'd0});
        end
    endtask

    initial begin
        rst      = 1'b1;
        pixel_in = '0;
        repeat (3) begin
            @(negedge clk);
            check_reset();
        end
        rst = 1'b0;
        // 3 full frames plus the run up to hpos = 5, vpos = 2 of the fourth.
        run(3 * FT + 5 * HT + 9 + 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        run(100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
